// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller (master) and its
// datapath (slave): instruction/status inputs, enables, mux selects and status.
interface multicycle_ctrl_if;
  logic [6:0] Opcode;
  logic       flag;
  logic       mem_ready;
  logic       PCwrite;
  logic       IRwrite;
  logic       AdrSrc;
  logic       DMwrite;
  logic       RegWrite;
  logic [1:0] ALUsrcA;
  logic [1:0] ALUsrcB;
  logic [1:0] ALUop;
  logic [1:0] ResultSrc;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  Opcode, flag, mem_ready,
    output PCwrite, IRwrite, AdrSrc, DMwrite, RegWrite,
    output ALUsrcA, ALUsrcB, ALUop, ResultSrc,
    output instr_done, illegal, state_dbg
  );

  modport slave (
    output Opcode, flag, mem_ready,
    input  PCwrite, IRwrite, AdrSrc, DMwrite, RegWrite,
    input  ALUsrcA, ALUsrcB, ALUop, ResultSrc,
    input  instr_done, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multi-cycle RV32I datapath (fetch/decode/exec/mem/wb).
// Optional macro MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready = 1.
module multicycle_ctrl #(
  parameter int unsigned RESET_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    JALR1  = 4'd11,
    JALR2  = 4'd12,
    LUI    = 4'd13,
    AUIPC  = 4'd14,
    TRAP   = 4'd15
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       adrsrc;
    logic       dmwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       done;
  } ctrl_t;

  localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  ctrl_t      ctrl_q;
  logic       illegal_q;
  logic       mem_ok_s;
  logic       stall_s;
  ctrl_t      gated_s;
  ctrl_t      out_s;

`ifdef MEM_WAIT_EN
  assign mem_ok_s = bus.mem_ready;
`else
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = bus.mem_ready;
  assign mem_ok_s           = 1'b1;
`endif

  // Moore output table; FETCH is silent while the post-reset hold runs.
  function automatic ctrl_t decode_outputs(input state_e s, input logic [3:0] hold);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        if (hold == 4'd0) begin
          c.irwrite   = 1'b1;
          c.pcwrite   = 1'b1;
          c.adrsrc    = 1'b0;
          c.alusrca   = 2'b00;
          c.alusrcb   = 2'b10;
          c.aluop     = 2'b00;
          c.resultsrc = 2'b10;
        end else begin
          c = '0;
        end
      end
      DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b00;
      end
      MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b00;
      end
      MEMRD: begin
        c.adrsrc    = 1'b1;
        c.resultsrc = 2'b00;
      end
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
        c.done      = 1'b1;
      end
      MEMWR: begin
        c.adrsrc    = 1'b1;
        c.resultsrc = 2'b00;
        c.dmwrite   = 1'b1;
        c.done      = 1'b1;
      end
      EXECR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b00;
        c.aluop   = 2'b10;
      end
      EXECI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      LUI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 2'b11;
      end
      AUIPC: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b00;
      end
      ALUWB: begin
        c.resultsrc = 2'b00;
        c.regwrite  = 1'b1;
        c.done      = 1'b1;
      end
      // PCwrite here comes from the live branch flag, added outside the register.
      BRANCH: begin
        c.alusrca   = 2'b10;
        c.alusrcb   = 2'b00;
        c.aluop     = 2'b01;
        c.resultsrc = 2'b00;
        c.done      = 1'b1;
      end
      JAL, JALR2: begin
        c.alusrca   = 2'b01;
        c.alusrcb   = 2'b10;
        c.aluop     = 2'b00;
        c.resultsrc = 2'b00;
        c.pcwrite   = 1'b1;
      end
      JALR1: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b00;
      end
      TRAP: begin
        c = '0;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state and hold-counter logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      FETCH: begin
        if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else if (mem_ok_s) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (bus.Opcode)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          7'b1100111:             state_d = JALR1;
          7'b0110111:             state_d = LUI;
          7'b0010111:             state_d = AUIPC;
          default:                state_d = TRAP;
        endcase
      end
      MEMADR: begin
        if (bus.Opcode == 7'b0100011) begin
          state_d = MEMWR;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMRD: begin
        if (mem_ok_s) begin
          state_d = MEMWB;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMWR: begin
        if (mem_ok_s) begin
          state_d = FETCH;
        end else begin
          state_d = MEMWR;
        end
      end
      MEMWB, ALUWB, BRANCH: state_d = FETCH;
      EXECR, EXECI, LUI, AUIPC, JAL, JALR2: state_d = ALUWB;
      JALR1: state_d = JALR2;
      TRAP:  state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // State, hold counter, registered Moore outputs and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      hold_q    <= HOLD_INIT;
      ctrl_q    <= decode_outputs(FETCH, HOLD_INIT);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      ctrl_q    <= decode_outputs(state_d, hold_d);
      illegal_q <= illegal_q | (state_d == TRAP);
    end
  end

  // A stalled memory state keeps its selects but must not commit anything.
  assign stall_s = (state_q inside {FETCH, MEMRD, MEMWR}) & ~mem_ok_s;

  // Stall gating and branch PC enable on top of the registered outputs.
  always_comb begin
    gated_s         = ctrl_q;
    gated_s.pcwrite = (ctrl_q.pcwrite & ~stall_s) | ((state_q == BRANCH) & bus.flag);
    gated_s.irwrite = ctrl_q.irwrite & ~stall_s;
    gated_s.dmwrite = ctrl_q.dmwrite & ~stall_s;
    gated_s.done    = ctrl_q.done & ~stall_s;
  end

  // rst forces everything quiet in the same cycle, so an aborted instruction never writes back.
  assign out_s = rst ? ctrl_t'(0) : gated_s;

  assign bus.PCwrite    = out_s.pcwrite;
  assign bus.IRwrite    = out_s.irwrite;
  assign bus.AdrSrc     = out_s.adrsrc;
  assign bus.DMwrite    = out_s.dmwrite;
  assign bus.RegWrite   = out_s.regwrite;
  assign bus.ALUsrcA    = out_s.alusrca;
  assign bus.ALUsrcB    = out_s.alusrcb;
  assign bus.ALUop      = out_s.aluop;
  assign bus.ResultSrc  = out_s.resultsrc;
  assign bus.instr_done = out_s.done;
  assign bus.illegal    = illegal_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction table plus hand-written reset, abort,
// trap and (with MEM_WAIT_EN) fetch-stall sequences, checked cycle by cycle.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, dmw, rw;
    logic [1:0] sa, sb, op, rs;
    logic       done, ill;
  } obs_t;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        f;
    int          n;
    logic [19:0] st;
  } vec_t;

  obs_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[10];
  int    errors   = 0;
  int    checks   = 0;
  int    done_cnt = 0;
  int    retired  = 0;

  function automatic vec_t mk(input string nm, input logic [6:0] op, input logic f,
                              input int n, input logic [19:0] st);
    vec_t v;
    v.name = nm; v.op = op; v.f = f; v.n = n; v.st = st;
    return v;
  endfunction

  // Expected outputs of each state, written from the state descriptions.
  function automatic obs_t exp_out(input logic [3:0] st, input logic f, input logic ill);
    obs_t e;
    e = '0;
    e.st  = st;
    e.ill = ill;
    case (st)
      4'd0:  begin e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  begin e.adr = 1'b1; end
      4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.dmw = 1'b1; e.done = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.op = 2'b10; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.op = 2'b10; end
      4'd8:  begin e.rw = 1'b1; e.done = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.op = 2'b01; e.pcw = f; e.done = 1'b1; end
      4'd10, 4'd12: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      4'd11: begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd13: begin e.sb = 2'b01; e.op = 2'b11; end
      4'd14: begin e.sa = 2'b01; e.sb = 2'b01; end
      default: begin e.st = st; end
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state_dbg; o.pcw = bus.PCwrite; o.irw = bus.IRwrite;
    o.adr = bus.AdrSrc; o.dmw = bus.DMwrite; o.rw = bus.RegWrite;
    o.sa = bus.ALUsrcA; o.sb = bus.ALUsrcB; o.op = bus.ALUop; o.rs = bus.ResultSrc;
    o.done = bus.instr_done; o.ill = bus.illegal;
    return o;
  endfunction

  task automatic push_rec(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_now();
    obs_t  got, e;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = sample();
      if (got.done === 1'b1) done_cnt++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got=%h required=%h (st,pcw,irw,adr,dmw,rw,sa,sb,op,rs,done,ill)",
                 nm, got, e);
      end
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    push_rec(nm, obs_t'(0));
    #1 check_now();
  endtask

  task automatic run_vec(input vec_t v, input int stalls);
    obs_t s;
    @(negedge clk);
    bus.Opcode = v.op;
    bus.flag   = v.f;
    for (int i = 0; i < stalls; i++) begin
      bus.mem_ready = 1'b0;
      s = exp_out(4'd0, 1'b0, 1'b0);
      s.irw = 1'b0;
      s.pcw = 1'b0;
      push_rec({v.name, "/stall"}, s);
      #1 check_now();
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    for (int k = 0; k < v.n; k++) begin
      if (k > 0) @(negedge clk);
      push_rec($sformatf("%s/c%0d", v.name, k + 1), exp_out(v.st[4*k +: 4], v.f, 1'b0));
      #1 check_now();
    end
    retired++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    obs_t r;
    bus.Opcode    = 7'b0000000;
    bus.flag      = 1'b0;
    bus.mem_ready = 1'b1;
    rst           = 1'b1;

    vecs[0] = mk("addi",   7'b0010011, 1'b1, 4, {4'd0, 4'd8,  4'd7,  4'd1, 4'd0});
    vecs[1] = mk("lw",     7'b0000011, 1'b0, 5, {4'd4, 4'd3,  4'd2,  4'd1, 4'd0});
    vecs[2] = mk("sw",     7'b0100011, 1'b1, 4, {4'd0, 4'd5,  4'd2,  4'd1, 4'd0});
    vecs[3] = mk("beq_t",  7'b1100011, 1'b1, 3, {4'd0, 4'd0,  4'd9,  4'd1, 4'd0});
    vecs[4] = mk("beq_nt", 7'b1100011, 1'b0, 3, {4'd0, 4'd0,  4'd9,  4'd1, 4'd0});
    vecs[5] = mk("jalr",   7'b1100111, 1'b0, 5, {4'd8, 4'd12, 4'd11, 4'd1, 4'd0});
    vecs[6] = mk("add",    7'b0110011, 1'b1, 4, {4'd0, 4'd8,  4'd6,  4'd1, 4'd0});
    vecs[7] = mk("jal",    7'b1101111, 1'b0, 4, {4'd0, 4'd8,  4'd10, 4'd1, 4'd0});
    vecs[8] = mk("lui",    7'b0110111, 1'b1, 4, {4'd0, 4'd8,  4'd13, 4'd1, 4'd0});
    vecs[9] = mk("auipc",  7'b0010111, 1'b0, 4, {4'd0, 4'd8,  4'd14, 4'd1, 4'd0});

    // Three reset edges, then two hold cycles before the first fetch.
    idle_check("reset_c1");
    idle_check("reset_c2");
    @(negedge clk);
    rst = 1'b0;
    push_rec("hold_c1", obs_t'(0));
    #1 check_now();
    idle_check("hold_c2");

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 0);

    // Reset arriving in MEMWB must suppress the register write.
    @(negedge clk);
    bus.Opcode = 7'b0000011;
    push_rec("abort/fetch", exp_out(4'd0, 1'b0, 1'b0));
    #1 check_now();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      push_rec("abort/pre", exp_out(4'(k), 1'b0, 1'b0));
      #1 check_now();
    end
    @(negedge clk);
    rst = 1'b1;
    r = '0;
    r.st = 4'd4;
    push_rec("abort/memwb_in_rst", r);
    #1 check_now();
    @(negedge clk);
    rst = 1'b0;
    push_rec("abort/hold_c1", obs_t'(0));
    #1 check_now();
    idle_check("abort/hold_c2");

`ifdef MEM_WAIT_EN
    run_vec(vecs[0], 3);
`else
    run_vec(vecs[0], 0);
`endif

    // Unsupported opcode: TRAP with illegal held, no enables.
    @(negedge clk);
    bus.Opcode = 7'b1111111;
    push_rec("trap/fetch", exp_out(4'd0, 1'b0, 1'b0));
    #1 check_now();
    @(negedge clk);
    push_rec("trap/decode", exp_out(4'd1, 1'b0, 1'b0));
    #1 check_now();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      push_rec($sformatf("trap/hold%0d", k), exp_out(4'd15, 1'b0, 1'b1));
      #1 check_now();
    end
    @(negedge clk);
    rst = 1'b1;
    r = '0;
    r.st  = 4'd15;
    r.ill = 1'b1;
    push_rec("trap/rst_asserted", r);
    #1 check_now();
    @(negedge clk);
    rst = 1'b0;
    push_rec("trap/cleared_hold1", obs_t'(0));
    #1 check_now();
    idle_check("trap/cleared_hold2");
    run_vec(vecs[0], 0);

    checks++;
    if (done_cnt != retired) begin
      errors++;
      $display("FAIL instr_done_count: got=%0d required=%0d", done_cnt, retired);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got=%0d entries required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style FSM that sequences the multi-cycle RV32I datapath variant (shared instruction/data memory, IR/OldPC/ALUOut/Data registers), replacing the single-cycle decoder for that build.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives register enables, mux selects and the ALU class.
- Reports instruction retirement and illegal opcodes.

Parameters:
- RESET_HOLD, 0, extra cycles to stay in FETCH-idle after rst deasserts (0..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- Opcode  in  7  IR[6:0]; valid from DECODE onward
- flag  in  1  ALU branch-condition result (combinational, same cycle)
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- PCwrite  out  1  PC register load enable
- IRwrite  out  1  IR and OldPC load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- DMwrite  out  1  memory write enable
- RegWrite  out  1  register-file write enable
- ALUsrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUsrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ALUop  out  2  00 = add, 01 = branch compare, 10 = funct decode, 11 = upper-immediate
- ResultSrc  out  2  00 = ALUOut, 01 = memory data register, 10 = ALU result
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  sticky; set on an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR1 = 11, JALR2 = 12, LUI = 13, AUIPC = 14, TRAP = 15.
- Reset:
  - While rst = 1, state = FETCH and the hold counter = RESET_HOLD.
  - All enables (PCwrite, IRwrite, DMwrite, RegWrite), instr_done and illegal = 0.
  - All selects = 0.
  - rst mid-instruction aborts it with no writeback.
- Default in every state: all enables 0, selects 0, instr_done 0.
- FETCH:
  - While hold counter > 0: counter decrements, no outputs.
  - Otherwise: AdrSrc = 0, IRwrite = 1, ALUsrcA = 00, ALUsrcB = 10, ALUop = 00, ResultSrc = 10, PCwrite = 1; go to DECODE.
- DECODE:
  - ALUsrcA = 01, ALUsrcB = 01, ALUop = 00, so branch/jal target goes into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other opcode -> TRAP
- MEMADR: ALUsrcA = 10, ALUsrcB = 01, ALUop = 00; go to MEMRD for loads, MEMWR for stores.
- MEMRD: AdrSrc = 1, ResultSrc = 00; go to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_done = 1; go to FETCH.
- MEMWR: AdrSrc = 1, ResultSrc = 00, DMwrite = 1, instr_done = 1; go to FETCH.
- EXECR: ALUsrcA = 10, ALUsrcB = 00, ALUop = 10; go to ALUWB.
- EXECI: ALUsrcA = 10, ALUsrcB = 01, ALUop = 10; go to ALUWB.
- LUI: ALUsrcB = 01, ALUop = 11; go to ALUWB.
- AUIPC: ALUsrcA = 01, ALUsrcB = 01, ALUop = 00; go to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_done = 1; go to FETCH.
- BRANCH:
  - ALUsrcA = 10, ALUsrcB = 00, ALUop = 01, ResultSrc = 00.
  - PCwrite = flag (combinational), instr_done = 1; go to FETCH.
- JAL:
  - ALUsrcA = 01, ALUsrcB = 10, ALUop = 00, ResultSrc = 00, PCwrite = 1.
  - ALUOut captures OldPC + 4; go to ALUWB.
- JALR1: ALUsrcA = 10, ALUsrcB = 01, ALUop = 00; go to JALR2.
- JALR2:
  - Same outputs as JAL; PC = ALUOut with bit 0 cleared by the datapath.
  - Go to ALUWB.
- TRAP: illegal = 1; state stays TRAP until rst; no enables asserted.
- Cycle counts from FETCH:
  - load 5, store 4, R/I-type 4
  - branch 3
  - jal 4, jalr 5
  - lui/auipc 4
- instr_done count equals the number of retired instructions; it never pulses in TRAP or during the hold.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR stall while mem_ready = 0.
  - During a stall the state's mux selects are held; IRwrite, PCwrite, DMwrite and instr_done are gated to 0.
  - The state advances, with its enables asserted, in the first cycle mem_ready = 1.
- Undefined: mem_ready is ignored; every memory state takes exactly 1 cycle.

Test Plan:
- rst = 1 for 3 cycles, RESET_HOLD = 2 -> all enables 0 and state_dbg = 0 during reset and for 2 further cycles; IRwrite = 1 in the 3rd post-reset cycle.
- addi (0010011) -> states 0, 1, 7, 8; RegWrite = 1 and instr_done = 1 only in cycle 4.
- lw (0000011) -> states 0, 1, 2, 3, 4; AdrSrc = 1 in MEMRD; ResultSrc = 01 and RegWrite = 1 in MEMWB. sw (0100011) -> DMwrite = 1 in exactly one cycle (state 5).
- beq (1100011) run twice, flag = 1 then flag = 0 -> PCwrite = 1 in BRANCH on the first run and 0 on the second; both take 3 cycles.
- jalr (1100111) -> states 0, 1, 11, 12, 8; PCwrite = 1 in state 12; RegWrite = 1 in state 8.
- Opcode 1111111 -> TRAP; illegal = 1 held for 10 cycles; rst pulse clears it and restarts at FETCH. With MEM_WAIT_EN and mem_ready = 0 for 3 cycles in FETCH -> IRwrite = 0 for those 3 cycles, then 1.
